// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit FIFO sequencer.
package uart_pkg;

    localparam int unsigned DataWidthDef = 8;
    localparam int unsigned CharsW       = 16;
    localparam int unsigned TimerW       = 8;

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StWait,
        StLoad,
        StGap
    } seq_state_e;

endpackage

// File: rtl/uart_tx_fifo_sequencer_if.sv
// FIFO read port and transmitter load port seen by the sequencer.
interface uart_tx_fifo_sequencer_if
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DataWidthDef
);
    logic                  fifo_empty;
    logic                  fifo_read_n;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  tx_busy;
    logic                  tx_load;
    logic [DATA_WIDTH-1:0] tx_data;

    modport master (
        input  fifo_empty, fifo_data, tx_busy,
        output fifo_read_n, tx_load, tx_data
    );

    modport slave (
        output fifo_empty, fifo_data, tx_busy,
        input  fifo_read_n, tx_load, tx_data
    );
endinterface

// File: rtl/uart_tx_seq_timer.sv
// Loadable down-counter; done while the current count is on its last cycle.
module uart_tx_seq_timer
    import uart_pkg::*;
#(
    parameter int unsigned Width = TimerW
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    output logic             done_o
);
    logic [Width-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - Width'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q <= Width'(1));
endmodule

// File: rtl/uart_tx_fifo_sequencer.sv
// Drains the TX FIFO into the UART transmitter one character at a time.
// Optional UART_TX_CTS_EN adds a synchronised cts_n_i gate on loading.
module uart_tx_fifo_sequencer
    import uart_pkg::*;
#(
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned GAP_CYCLES = 0,
    parameter int unsigned DATA_WIDTH = DataWidthDef
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     enable_i,
    input  logic                     flush_i,
`ifdef UART_TX_CTS_EN
    input  logic                     cts_n_i,
`endif
    uart_tx_fifo_sequencer_if.master bus_io,
    output logic                     seq_busy_o,
    output logic [CharsW-1:0]        chars_sent_o
);
    localparam int unsigned GapLoad = (GAP_CYCLES == 0) ? 1 : GAP_CYCLES;

    seq_state_e            state_q, state_d;
    logic                  fifo_read_n_q, fifo_read_n_d;
    logic                  tx_load_q, tx_load_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic [CharsW-1:0]     chars_q, chars_d;
    logic                  flush_q, flush_d;
    logic                  timer_load, timer_done;
    logic [TimerW-1:0]     timer_val;
    logic                  cts_ok;
    logic                  go;

`ifdef UART_TX_CTS_EN
    logic [1:0] cts_sync_q;

    // Resets to "not clear" so nothing is loaded before CTS is seen.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cts_sync_q <= 2'b11;
        end else begin
            cts_sync_q <= {cts_sync_q[0], cts_n_i};
        end
    end
    assign cts_ok = ~cts_sync_q[1];
`else
    assign cts_ok = 1'b1;
`endif

    uart_tx_seq_timer #(
        .Width(TimerW)
    ) u_timer (
        .clock     (clock),
        .reset_n   (reset_n),
        .load_i    (timer_load),
        .load_val_i(timer_val),
        .done_o    (timer_done)
    );

    assign go = (state_q == StIdle) && !bus_io.fifo_empty && (enable_i || flush_i);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (go) state_d = StRd;
            StRd:   state_d = StWait;
            StWait: if (timer_done) state_d = flush_q ? StIdle : StLoad;
            // tx_load_q high means the pulse is in progress; leave as it ends.
            StLoad: if (tx_load_q) state_d = StGap;
            StGap:  if (timer_done) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        fifo_read_n_d = 1'b1;
        tx_load_d     = 1'b0;
        tx_data_d     = tx_data_q;
        chars_d       = chars_q;
        flush_d       = flush_q;
        timer_load    = 1'b0;
        timer_val     = '0;
        unique case (state_q)
            StIdle: begin
                if (go) begin
                    fifo_read_n_d = 1'b0;
                    flush_d       = flush_i;
                end
            end
            StRd: begin
                timer_load = 1'b1;
                timer_val  = TimerW'(RD_LATENCY);
            end
            StWait: begin
                if (timer_done) tx_data_d = bus_io.fifo_data;
            end
            StLoad: begin
                if (tx_load_q) begin
                    chars_d    = chars_q + CharsW'(1);
                    timer_load = 1'b1;
                    timer_val  = TimerW'(GapLoad);
                end else if (!bus_io.tx_busy && cts_ok) begin
                    tx_load_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fifo_read_n_q <= 1'b1;
            tx_load_q     <= 1'b0;
            tx_data_q     <= '0;
            chars_q       <= '0;
            flush_q       <= 1'b0;
        end else begin
            fifo_read_n_q <= fifo_read_n_d;
            tx_load_q     <= tx_load_d;
            tx_data_q     <= tx_data_d;
            chars_q       <= chars_d;
            flush_q       <= flush_d;
        end
    end

    assign bus_io.fifo_read_n = fifo_read_n_q;
    assign bus_io.tx_load     = tx_load_q;
    assign bus_io.tx_data     = tx_data_q;
    assign seq_busy_o         = (state_q != StIdle);
    assign chars_sent_o       = chars_q;
endmodule

// File: tb/tb_uart_tx_fifo_sequencer.sv
// Bench: FIFO and transmitter models around two sequencers (gap 0 and gap 10).
module tb_uart_tx_fifo_sequencer;
    import uart_pkg::*;

    localparam int unsigned Lat = 2;
    localparam int unsigned Gap1 = 10;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic enable = 1'b0;
    logic flush = 1'b0;
    logic tx_busy = 1'b0;
    logic sel = 1'b0;
    logic [7:0] m_data = 8'h00;
`ifdef UART_TX_CTS_EN
    logic cts_n = 1'b0;
`endif

    logic        seq_busy0, seq_busy1;
    logic [15:0] chars0, chars1;
    logic        m_read_n;

    int total = 0;
    int bad = 0;

    // FIFO model: tasks write fmem/wr_n, the monitor consumes rd_n.
    logic [7:0] fmem [0:1023];
    int wr_n = 0;
    int rd_n = 0;
    logic       pipe_v = 1'b0;
    logic [7:0] pipe_d = 8'h00;

    int cyc = 0;
    int rd_cnt = 0;
    int ld_cnt = 0;
    int rd_off = 0;
    int viol = 0;
    int underflow = 0;
    int busy_cnt = 0;
    logic [7:0] ld_data [0:1023];
    int ld_cyc [0:1023];
    logic bp_mode = 1'b0;
    logic rnd_mode = 1'b0;
    int exp_chars0 = 0;

    uart_tx_fifo_sequencer_if #(.DATA_WIDTH(8)) bus0 ();
    uart_tx_fifo_sequencer_if #(.DATA_WIDTH(8)) bus1 ();

    assign bus0.fifo_empty = sel | (wr_n == rd_n);
    assign bus1.fifo_empty = !sel | (wr_n == rd_n);
    assign bus0.fifo_data  = m_data;
    assign bus1.fifo_data  = m_data;
    assign bus0.tx_busy    = tx_busy;
    assign bus1.tx_busy    = tx_busy;
    assign m_read_n        = sel ? bus1.fifo_read_n : bus0.fifo_read_n;

    uart_tx_fifo_sequencer #(.RD_LATENCY(Lat), .GAP_CYCLES(0), .DATA_WIDTH(8)) dut0 (
        .clock       (clock),
        .reset_n     (reset_n),
        .enable_i    (enable),
        .flush_i     (flush),
`ifdef UART_TX_CTS_EN
        .cts_n_i     (cts_n),
`endif
        .bus_io      (bus0),
        .seq_busy_o  (seq_busy0),
        .chars_sent_o(chars0)
    );

    uart_tx_fifo_sequencer #(.RD_LATENCY(Lat), .GAP_CYCLES(Gap1), .DATA_WIDTH(8)) dut1 (
        .clock       (clock),
        .reset_n     (reset_n),
        .enable_i    (enable),
        .flush_i     (flush),
`ifdef UART_TX_CTS_EN
        .cts_n_i     (cts_n),
`endif
        .bus_io      (bus1),
        .seq_busy_o  (seq_busy1),
        .chars_sent_o(chars1)
    );

    always #5 clock = ~clock;

    // Read data is valid only in the single cycle a latency-2 FIFO presents it.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pipe_v = 1'b0;
            busy_cnt = 0;
            m_data <= 8'h00;
        end else begin
            cyc = cyc + 1;
            m_data <= pipe_v ? pipe_d : 8'($urandom);
            pipe_v = 1'b0;
            if (m_read_n == 1'b0) begin
                if (rd_cnt - ld_cnt != rd_off) viol = viol + 1;
                if (wr_n == rd_n) begin
                    underflow = underflow + 1;
                    pipe_d = 8'($urandom);
                end else begin
                    pipe_d = fmem[rd_n % 1024];
                    rd_n = rd_n + 1;
                end
                pipe_v = 1'b1;
                rd_cnt = rd_cnt + 1;
            end
            if (bus0.tx_load || bus1.tx_load) begin
                ld_data[ld_cnt % 1024] = bus0.tx_load ? bus0.tx_data : bus1.tx_data;
                ld_cyc[ld_cnt % 1024] = cyc;
                ld_cnt = ld_cnt + 1;
                busy_cnt = 20;
            end else if (busy_cnt > 0) begin
                busy_cnt = busy_cnt - 1;
            end
        end
    end

    always @(negedge clock) begin
        tx_busy = bp_mode ? (busy_cnt != 0) : (rnd_mode ? 1'($urandom_range(0, 1)) : 1'b0);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic push(input logic [7:0] b);
        fmem[wr_n % 1024] = b;
        wr_n = wr_n + 1;
    endtask

    task automatic wait_loads(input string name, input int n, input int budget);
        for (int i = 0; i < budget && ld_cnt < n; i++) @(negedge clock);
        total++;
        if (ld_cnt < n) begin
            bad++;
            $display("FAIL %s_timeout: loads=%0d required=%0d", name, ld_cnt, n);
        end
    endtask

    task automatic wait_idle(input int budget);
        repeat (2) @(negedge clock);
        for (int i = 0; i < budget && (wr_n != rd_n || seq_busy0 || seq_busy1); i++)
            @(negedge clock);
        total++;
        if (wr_n != rd_n || seq_busy0 || seq_busy1) begin
            bad++;
            $display("FAIL idle_timeout: queued=%0d busy=%b", wr_n - rd_n, seq_busy0);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        total++;
        if (bus0.fifo_read_n !== 1'b1 || bus0.tx_load !== 1'b0) begin
            bad++;
            $display("FAIL reset_strobes: read_n=%b load=%b required 1/0",
                     bus0.fifo_read_n, bus0.tx_load);
        end
        total++;
        if (bus0.tx_data !== 8'h00 || chars0 !== 16'h0000 || seq_busy0 !== 1'b0) begin
            bad++;
            $display("FAIL reset_values: data=%h chars=%h busy=%b required 00/0000/0",
                     bus0.tx_data, chars0, seq_busy0);
        end
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
    endtask

    task automatic test_single();
        int base, rbase, t0;
        enable = 1'b1;
        base = ld_cnt;
        rbase = rd_cnt;
        rd_off = rd_cnt - ld_cnt;
        push(8'hA5);
        t0 = cyc + 1;
        wait_loads("single", base + 1, 50);
        repeat (2) @(negedge clock);
        exp_chars0 = exp_chars0 + 1;
        total++;
        if (rd_cnt - rbase !== 1) begin
            bad++;
            $display("FAIL single_reads: got=%0d required=1", rd_cnt - rbase);
        end
        total++;
        if (ld_cyc[base] - t0 !== 5) begin
            bad++;
            $display("FAIL single_latency: got=%0d required=5", ld_cyc[base] - t0);
        end
        total++;
        if (ld_data[base] !== 8'hA5) begin
            bad++;
            $display("FAIL single_data: got=%h required=a5", ld_data[base]);
        end
        total++;
        if (chars0 !== 16'(exp_chars0)) begin
            bad++;
            $display("FAIL single_chars: got=%0d required=%0d", chars0, exp_chars0);
        end
    endtask

    task automatic test_throughput();
        int base;
        logic [7:0] b0, b1;
        base = ld_cnt;
        b0 = 8'($urandom);
        b1 = 8'($urandom);
        push(b0);
        push(b1);
        wait_loads("throughput", base + 2, 60);
        exp_chars0 = exp_chars0 + 2;
        total++;
        if (ld_cyc[base + 1] - ld_cyc[base] !== 4 + Lat + 1) begin
            bad++;
            $display("FAIL throughput_spacing: got=%0d required=%0d",
                     ld_cyc[base + 1] - ld_cyc[base], 4 + Lat + 1);
        end
        total++;
        if (ld_data[base] !== b0 || ld_data[base + 1] !== b1) begin
            bad++;
            $display("FAIL throughput_data: got=%h,%h required=%h,%h",
                     ld_data[base], ld_data[base + 1], b0, b1);
        end
    endtask

    task automatic test_back_pressure();
        int base, rbase, vbase;
        wait_idle(50);
        bp_mode = 1'b1;
        base = ld_cnt;
        rbase = rd_cnt;
        vbase = viol;
        rd_off = rd_cnt - ld_cnt;
        push(8'h01);
        push(8'h02);
        push(8'h03);
        wait_loads("backpressure", base + 3, 300);
        wait_idle(60);
        exp_chars0 = exp_chars0 + 3;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (ld_data[base + i] !== 8'(i + 1)) begin
                bad++;
                $display("FAIL bp_data%0d: got=%h required=%h", i, ld_data[base + i], 8'(i + 1));
            end
        end
        for (int i = 1; i < 3; i++) begin
            total++;
            if (ld_cyc[base + i] - ld_cyc[base + i - 1] !== 22) begin
                bad++;
                $display("FAIL bp_spacing%0d: got=%0d required=22", i,
                         ld_cyc[base + i] - ld_cyc[base + i - 1]);
            end
        end
        total++;
        if (rd_cnt - rbase !== 3 || viol - vbase !== 0) begin
            bad++;
            $display("FAIL bp_reads: reads=%0d early_reads=%0d required 3/0",
                     rd_cnt - rbase, viol - vbase);
        end
        bp_mode = 1'b0;
    endtask

    task automatic test_flush();
        int base, rbase;
        wait_idle(60);
        enable = 1'b0;
        flush = 1'b1;
        base = ld_cnt;
        rbase = rd_cnt;
        for (int i = 0; i < 4; i++) push(8'($urandom));
        wait_idle(200);
        flush = 1'b0;
        rd_off = rd_cnt - ld_cnt;
        total++;
        if (rd_cnt - rbase !== 4 || ld_cnt - base !== 0) begin
            bad++;
            $display("FAIL flush_counts: reads=%0d loads=%0d required 4/0",
                     rd_cnt - rbase, ld_cnt - base);
        end
        total++;
        if (bus0.fifo_empty !== 1'b1 || chars0 !== 16'(exp_chars0)) begin
            bad++;
            $display("FAIL flush_end: empty=%b chars=%0d required 1/%0d",
                     bus0.fifo_empty, chars0, exp_chars0);
        end
    endtask

    task automatic test_random();
        logic [7:0] exp_q[$];
        logic [7:0] b;
        int base, vbase, n;
        n = 12;
        enable = 1'b1;
        rnd_mode = 1'b1;
        base = ld_cnt;
        vbase = viol;
        rd_off = rd_cnt - ld_cnt;
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            push(b);
            exp_q.push_back(b);
            if ($urandom_range(0, 3) == 0) enable = 1'b0;
            repeat ($urandom_range(0, 12)) @(negedge clock);
            enable = 1'b1;
        end
        wait_loads("random", base + n, 2000);
        repeat (3) @(negedge clock);
        exp_chars0 = exp_chars0 + n;
        for (int i = 0; i < n; i++) begin
            total++;
            if (ld_data[base + i] !== exp_q[i]) begin
                bad++;
                $display("FAIL random_data%0d: got=%h required=%h", i, ld_data[base + i], exp_q[i]);
            end
        end
        total++;
        if (chars0 !== 16'(exp_chars0) || viol - vbase !== 0 || underflow !== 0) begin
            bad++;
            $display("FAIL random_summary: chars=%0d early_reads=%0d underflow=%0d required %0d/0/0",
                     chars0, viol - vbase, underflow, exp_chars0);
        end
        rnd_mode = 1'b0;
    endtask

    task automatic test_gap();
        int base;
        wait_idle(60);
        sel = 1'b1;
        base = ld_cnt;
        rd_off = rd_cnt - ld_cnt;
        push(8'h3C);
        push(8'hC3);
        wait_loads("gap", base + 2, 100);
        repeat (2) @(negedge clock);
        total++;
        if (ld_cyc[base + 1] - ld_cyc[base] !== 4 + Lat + Gap1) begin
            bad++;
            $display("FAIL gap_spacing: got=%0d required=%0d",
                     ld_cyc[base + 1] - ld_cyc[base], 4 + Lat + Gap1);
        end
        total++;
        if (ld_data[base] !== 8'h3C || ld_data[base + 1] !== 8'hC3 || chars1 !== 16'd2) begin
            bad++;
            $display("FAIL gap_data: got=%h,%h chars=%0d required 3c,c3/2",
                     ld_data[base], ld_data[base + 1], chars1);
        end
        wait_idle(60);
        sel = 1'b0;
    endtask

`ifdef UART_TX_CTS_EN
    task automatic test_cts();
        int base, k;
        wait_idle(60);
        cts_n = 1'b1;
        repeat (4) @(negedge clock);
        base = ld_cnt;
        rd_off = rd_cnt - ld_cnt;
        push(8'h5A);
        repeat (20) @(negedge clock);
        total++;
        if (ld_cnt !== base || bus0.tx_load !== 1'b0 || seq_busy0 !== 1'b1) begin
            bad++;
            $display("FAIL cts_hold: loads=%0d load=%b busy=%b required %0d/0/1",
                     ld_cnt, bus0.tx_load, seq_busy0, base);
        end
        k = cyc;
        cts_n = 1'b0;
        wait_loads("cts", base + 1, 30);
        exp_chars0 = exp_chars0 + 1;
        total++;
        if (ld_cyc[base] - k !== 4 || ld_data[base] !== 8'h5A) begin
            bad++;
            $display("FAIL cts_release: edge_delta=%0d data=%h required 4/5a",
                     ld_cyc[base] - k, ld_data[base]);
        end
    endtask
`endif

    task automatic test_reset_mid();
        int rbase, base;
        wait_idle(60);
        enable = 1'b1;
        rbase = rd_cnt;
        rd_off = rd_cnt - ld_cnt;
        push(8'h77);
        for (int i = 0; i < 20 && rd_cnt == rbase; i++) @(negedge clock);
        total++;
        if (rd_cnt == rbase || seq_busy0 !== 1'b1) begin
            bad++;
            $display("FAIL midreset_setup: reads=%0d busy=%b required 1/1",
                     rd_cnt - rbase, seq_busy0);
        end
        reset_n = 1'b0;
        #1;
        total++;
        if (bus0.fifo_read_n !== 1'b1 || bus0.tx_load !== 1'b0 || seq_busy0 !== 1'b0) begin
            bad++;
            $display("FAIL midreset_ctrl: read_n=%b load=%b busy=%b required 1/0/0",
                     bus0.fifo_read_n, bus0.tx_load, seq_busy0);
        end
        total++;
        if (bus0.tx_data !== 8'h00 || chars0 !== 16'h0000) begin
            bad++;
            $display("FAIL midreset_regs: data=%h chars=%h required 00/0000",
                     bus0.tx_data, chars0);
        end
        @(negedge clock);
        reset_n = 1'b1;
        exp_chars0 = 0;
        base = ld_cnt;
        repeat (20) @(negedge clock);
        total++;
        if (ld_cnt !== base || seq_busy0 !== 1'b0 || chars0 !== 16'h0000) begin
            bad++;
            $display("FAIL midreset_after: loads=%0d busy=%b chars=%0d required 0/0/0",
                     ld_cnt - base, seq_busy0, chars0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_throughput();
        test_back_pressure();
        test_flush();
        test_random();
        test_gap();
`ifdef UART_TX_CTS_EN
        test_cts();
`endif
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo_sequencer.md
# uart_tx_fifo_sequencer

Drains the 128x8 transmit FIFO into the UART transmitter one character at a time, without losing data. It issues single-cycle active-low FIFO read strobes and absorbs the FIFO's registered read latency. It then hands each byte to the transmitter with a load pulse once the transmitter is idle, and optionally inserts inter-character gaps. It sits between the FIFO control block's read port and the TX shift-register block, and runs entirely on the system clock.

## Interface
- RD_LATENCY, 2: FIFO read latency in cycles; range 1–7.
- GAP_CYCLES, 0: idle cycles inserted after each tx_load; range 0–255.
- DATA_WIDTH, 8: character width.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- enable  in  1  level; permits starting new characters.
- flush  in  1  level; discards FIFO contents without transmitting.
- fifo_empty  in  1  FIFO empty flag.
- fifo_read_n  out  1  FIFO read strobe, active-low, registered.
- fifo_data  in  DATA_WIDTH  FIFO data_out.
- tx_busy  in  1  transmitter shifting a character.
- tx_load  out  1  one-cycle pulse; tx_data valid in the same cycle.
- tx_data  out  DATA_WIDTH  held character, registered.
- cts_n  in  1  clear-to-send, active-low; present only with UART_TX_CTS_EN.
- seq_busy  out  1  high in any state except IDLE.
- chars_sent  out  16  count of tx_load pulses; wraps from 0xFFFF to 0.

## Operation
- States:
  - IDLE: goes to RD when `!fifo_empty && (enable || flush)`.
  - RD: fifo_read_n is low for exactly this one cycle. Goes to WAIT.
  - WAIT: counts RD_LATENCY cycles, then captures fifo_data into tx_data. If flush was high at RD entry, goes to IDLE (byte discarded). Otherwise goes to LOAD.
  - LOAD: waits for `!tx_busy` and CTS permission, pulses tx_load for one cycle, increments chars_sent, then goes to GAP.
  - GAP: lasts `max(1, GAP_CYCLES)` cycles, ignoring tx_busy so the transmitter has time to raise it, then goes to IDLE.
- Exactly one FIFO read per character; the sequencer never issues a read while a previous byte is still in flight.
- The flush decision is latched at RD entry. Flush does not abort a byte already in LOAD; that byte is still transmitted.
- enable deassertion affects only the IDLE decision; an in-progress character always completes.
- If fifo_empty is sampled high in IDLE, no read is issued, which prevents underflow.

## Timing
- Reset values: fifo_read_n=1, tx_load=0, tx_data=0, seq_busy=0, chars_sent=0, state=IDLE, all counters 0.
- Reset mid-operation aborts immediately. A read already issued to the FIFO is lost, which is acceptable because the FIFO is reset in the same domain.
- Read timing: if IDLE decides at edge E0, fifo_read_n is low between E0 and E1, and tx_data is captured at edge E0+RD_LATENCY+1.
- Load timing: tx_load rises one edge after capture when tx_busy=0, so for RD_LATENCY=2 the best-case latency from fifo_empty falling to tx_load is 5 cycles.
- Back-to-back throughput with an idle transmitter is one character per 4+RD_LATENCY+max(1,GAP_CYCLES) cycles minimum.
- tx_busy is sampled each cycle in LOAD. If the transmitter drops busy and enable drops in the same cycle, the held byte is still loaded.
- chars_sent updates on the same edge that ends the tx_load pulse.

## Configuration
- UART_TX_CTS_EN defined: the cts_n port exists. LOAD additionally requires cts_n=0, and the byte is held indefinitely while cts_n=1. cts_n is synchronised through two flops inside the block, which adds 2 cycles of CTS latency.
- UART_TX_CTS_EN undefined: the port is absent and LOAD depends only on tx_busy.

## Structure
- Shared package uart_pkg holds:
  - the state enum (IDLE, RD, WAIT, LOAD, GAP);
  - the DATA_WIDTH default;
  - the chars_sent width constant.
- One sub-module, uart_tx_seq_timer: a loadable down-counter with a done flag. It serves both the WAIT latency count and the GAP count, so one instance is shared.

## Test plan
- Single byte: FIFO holds 0xA5, enable=1, tx_busy=0 → one fifo_read_n low cycle; tx_load 5 cycles later with tx_data=0xA5; chars_sent=1.
- Back-pressure: 3 bytes (0x01, 0x02, 0x03) queued and tx_busy held high 20 cycles after each load → exactly 3 reads and 3 loads in order; never a second read before the preceding load.
- Flush: 4 bytes queued, flush=1, enable=0 → 4 reads, zero tx_load, fifo_empty=1 at the end, chars_sent unchanged.
- Reset mid-WAIT: assert reset_n=0 during WAIT → all outputs at reset values immediately; after release, IDLE is entered with no spurious tx_load.
- GAP_CYCLES=10: 2 bytes queued with tx_busy=0 → the two tx_load pulses are exactly 4+2+10 cycles apart.
- UART_TX_CTS_EN with cts_n=1 and a byte queued → state stays LOAD, tx_load=0. Drop cts_n → tx_load fires 3 cycles later.
